// File: rtl/int_ctrl_vec_if.sv
// ---------------------------------------------------------------------------
// int_ctrl_vec_if
//   Bundle between the CPU fetch/decode logic and the vectored interrupt
//   controller.
//   master : fetch/decode side. Drives irq, instruction, pc_curr,
//            take_branch and pc_branch.
//   slave  : the controller. Drives pc_int, int_wait, int_run, int_done,
//            pc_resume, active_src and pending.
// ---------------------------------------------------------------------------
interface int_ctrl_vec_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0] irq;
    logic [31:0]        instruction;
    logic [31:0]        pc_curr;
    logic               take_branch;
    logic [31:0]        pc_branch;
    logic [31:0]        pc_int;
    logic               int_wait;
    logic               int_run;
    logic               int_done;
    logic [31:0]        pc_resume;
    logic [4:0]         active_src;
    logic [NUM_SRC-1:0] pending;

    modport master (
        output irq, instruction, pc_curr, take_branch, pc_branch,
        input  pc_int, int_wait, int_run, int_done, pc_resume, active_src, pending
    );

    modport slave (
        input  irq, instruction, pc_curr, take_branch, pc_branch,
        output pc_int, int_wait, int_run, int_done, pc_resume, active_src, pending
    );
endinterface

// File: rtl/int_ctrl_vec.sv
// ---------------------------------------------------------------------------
// int_ctrl_vec
//   Vectored multi-source interrupt controller for the CPU fetch unit.
//   Level requests are captured into sticky pending bits, qualified by a
//   software mask (written by the OP_SETMASK instruction), and the lowest
//   eligible index is serviced: the vector-table entry is fetched, the
//   handler address is loaded into fetch with a one-cycle int_run pulse, and
//   the ISR runs until OP_RETI. A RETI drains the pipeline for DRAIN_CYCLES
//   cycles (a branch during the drain squashes it) before int_done pulses.
//
//   Ports
//     clk  : clock
//     rst  : synchronous, active-high reset
//     bus  : int_ctrl_vec_if.slave
//            in  irq[NUM_SRC], instruction[32], pc_curr[32],
//                take_branch, pc_branch[32]
//            out pc_int[32], int_wait, int_run, int_done, pc_resume[32],
//                active_src[5], pending[NUM_SRC]
// ---------------------------------------------------------------------------
module int_ctrl_vec #(
    parameter int          NUM_SRC      = 4,
    parameter logic [31:0] VEC_BASE     = 32'h8,
    parameter logic [31:0] VEC_STRIDE   = 32'h4,
    parameter int          FETCH_WAIT   = 3,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [5:0]  OP_SETMASK   = 6'b111111,
    parameter logic [5:0]  OP_RETI      = 6'b111110
) (
    input  logic         clk,
    input  logic         rst,
    int_ctrl_vec_if.slave bus
);

    localparam logic [3:0] ST_RST_VEC   = 4'd0;
    localparam logic [3:0] ST_RST_FETCH = 4'd1;
    localparam logic [3:0] ST_RST_RUN   = 4'd2;
    localparam logic [3:0] ST_IDLE      = 4'd3;
    localparam logic [3:0] ST_VEC_LOAD  = 4'd4;
    localparam logic [3:0] ST_VEC_FETCH = 4'd5;
    localparam logic [3:0] ST_WAIT      = 4'd6;
    localparam logic [3:0] ST_RUN       = 4'd7;
    localparam logic [3:0] ST_ISR       = 4'd8;
    localparam logic [3:0] ST_DRAIN     = 4'd9;

    localparam int              CNT_W      = 16;
    localparam logic [CNT_W-1:0] FW_LAST   = CNT_W'(FETCH_WAIT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    logic [3:0]         state_q, state_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [31:0]        pc_resume_q, pc_resume_d;
    logic [31:0]        handler_q, handler_d;
    logic [4:0]         active_src_q, active_src_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [5:0]         opcode;
    logic               is_setmask;
    logic               is_reti;
    logic [NUM_SRC-1:0] eligible;
    logic               any_eligible;
    logic [4:0]         winner;
    logic               accept;
    logic [31:0]        vec_addr;

    logic [31:0]        pc_int_c;
    logic               int_wait_c;
    logic               int_run_c;
    logic               int_done_c;

    assign opcode       = bus.instruction[31:26];
    assign is_setmask   = (opcode == OP_SETMASK);
    assign is_reti      = (opcode == OP_RETI);
    assign eligible     = pending_q & mask_q;
    assign any_eligible = |eligible;
    assign accept       = (state_q == ST_IDLE) && any_eligible;
    assign vec_addr     = VEC_BASE + (32'(active_src_q) * VEC_STRIDE);

    // Lowest eligible index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 5'(i);
            end
        end
    end

    // Mask bit i comes from instruction bit i+1. The pending clear on accept
    // takes precedence over a request arriving in the same cycle; a request
    // that is still high afterwards simply re-pends on the next edge.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign mask_d[gi]    = is_setmask ? bus.instruction[gi+1] : mask_q[gi];
        assign pending_d[gi] = (accept && (winner == 5'(gi))) ? 1'b0
                                                             : (pending_q[gi] | bus.irq[gi]);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        handler_d    = handler_q;
        active_src_d = active_src_q;
        pc_resume_d  = pc_resume_q;
        pc_int_c     = handler_q;
        int_wait_c   = 1'b0;
        int_run_c    = 1'b0;
        int_done_c   = 1'b0;

        case (state_q)
            ST_RST_VEC: begin
                pc_int_c   = 32'h0;
                int_wait_c = 1'b1;
                state_d    = ST_RST_FETCH;
            end
            ST_RST_FETCH: begin
                int_wait_c = 1'b1;
                handler_d  = bus.instruction;
                state_d    = ST_RST_RUN;
            end
            ST_RST_RUN: begin
                int_run_c = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_IDLE: begin
                if (any_eligible) begin
                    int_wait_c   = 1'b1;
                    active_src_d = winner;
                    pc_resume_d  = bus.take_branch ? bus.pc_branch : bus.pc_curr;
                    state_d      = ST_VEC_LOAD;
                end
            end
            ST_VEC_LOAD: begin
                int_wait_c = 1'b1;
                pc_int_c   = vec_addr;
                if (bus.take_branch) pc_resume_d = bus.pc_branch;
                state_d    = ST_VEC_FETCH;
            end
            ST_VEC_FETCH: begin
                int_wait_c = 1'b1;
                pc_int_c   = vec_addr;
                handler_d  = bus.instruction;
                cnt_d      = '0;
                if (bus.take_branch) pc_resume_d = bus.pc_branch;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                int_wait_c = 1'b1;
                pc_int_c   = vec_addr;
                if (bus.take_branch) pc_resume_d = bus.pc_branch;
                if (cnt_q == FW_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                int_run_c = 1'b1;
                state_d   = ST_ISR;
            end
            ST_ISR: begin
                // Branches inside the handler never affect the saved resume PC.
                if (is_reti) begin
                    int_wait_c = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A branch resolving during the drain means the RETI was on a
                // squashed path: the handler keeps running.
                if (bus.take_branch) begin
                    state_d = ST_ISR;
                end else if (cnt_q == DRAIN_LAST) begin
                    int_done_c = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    int_wait_c = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RST_VEC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RST_VEC;
            mask_q       <= '0;
            pending_q    <= '0;
            pc_resume_q  <= '0;
            handler_q    <= '0;
            active_src_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            pending_q    <= pending_d;
            pc_resume_q  <= pc_resume_d;
            handler_q    <= handler_d;
            active_src_q <= active_src_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.pc_int     = pc_int_c;
    assign bus.int_wait   = int_wait_c;
    assign bus.int_run    = int_run_c;
    assign bus.int_done   = int_done_c;
    assign bus.pc_resume  = pc_resume_q;
    assign bus.active_src = active_src_q;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_int_ctrl_vec.sv
`timescale 1ns/1ps
module tb_int_ctrl_vec;
    localparam int          NS     = 4;
    localparam int          FW     = 3;
    localparam int          DC     = 4;
    localparam logic [31:0] VB     = 32'h8;
    localparam logic [31:0] VS     = 32'h4;
    localparam logic [31:0] H_RST  = 32'h400;
    localparam logic [31:0] H_BASE = 32'h1000;
    localparam logic [31:0] I_NOP  = 32'h0;
    localparam logic [31:0] I_RETI = {6'b111110, 26'd0};

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_valid;
    logic [31:0] cpu_instr;

    int_ctrl_vec_if #(.NUM_SRC(NS)) bus ();

    int_ctrl_vec #(
        .NUM_SRC(NS), .VEC_BASE(VB), .VEC_STRIDE(VS),
        .FETCH_WAIT(FW), .DRAIN_CYCLES(DC),
        .OP_SETMASK(6'b111111), .OP_RETI(6'b111110)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [31:0] handler;
        logic [4:0]  src;
        logic [31:0] resume;
    } svc_t;
    svc_t sb_q[$];

    // Instruction memory: reset vector at 0, vector table entries hold
    // handler addresses H_BASE + k*0x100.
    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0) return H_RST;
        for (int k = 0; k < NS; k++) begin
            if (a == VB + VS * 32'(k)) return H_BASE + 32'(k) * 32'h100;
        end
        return I_NOP;
    endfunction

    function automatic logic [31:0] setmask(input logic [NS-1:0] m);
        return {6'b111111, 21'd0, m, 1'b0};
    endfunction

    always_comb bus.instruction = cpu_valid ? cpu_instr : imem(bus.pc_int);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_run(input int max, input string tag, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.int_run !== 1'b1 && n < max);
        chk(tag, 32'(bus.int_run), 32'd1);
    endtask

    // Call in an ISR cycle: issues RETI and counts cycles until int_done.
    task automatic reti_and_wait(input string tag, output int n);
        cpu_instr = I_RETI;
        cpu_valid = 1'b1;
        n = 0;
        do begin
            step();
            cpu_valid = 1'b0;
            n++;
        end while (bus.int_done !== 1'b1 && n < 20);
        chk(tag, 32'(bus.int_done), 32'd1);
    endtask

    // Scoreboard: every int_run pops one expected service record.
    always @(negedge clk) begin : monitor
        svc_t e;
        if (bus.int_run === 1'b1) begin
            chk("sb_avail", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_handler", bus.pc_int, e.handler);
                chk("sb_src", 32'(bus.active_src), 32'(e.src));
                chk("sb_resume", bus.pc_resume, e.resume);
                $display("run: src=%0d pc_int=0x%0h resume=0x%0h", bus.active_src, bus.pc_int, bus.pc_resume);
            end
        end
        if (bus.int_done === 1'b1) begin
            done_cnt++;
            $display("done: src=%0d resume=0x%0h", bus.active_src, bus.pc_resume);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        rst = 1'b1;
        cpu_valid = 1'b0;
        cpu_instr = I_NOP;
        bus.irq = '0;
        bus.pc_curr = 32'h100;
        bus.take_branch = 1'b0;
        bus.pc_branch = 32'h0;

        // 1: reset state and int_run timing after reset release
        repeat (2) @(posedge clk);
        step();
        chk("rst_pc_int", bus.pc_int, 32'h0);
        chk("rst_wait", 32'(bus.int_wait), 32'd1);
        chk("rst_run", 32'(bus.int_run), 32'd0);
        chk("rst_done", 32'(bus.int_done), 32'd0);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        sb_q.push_back('{H_RST, 5'd0, 32'h0});
        rst = 1'b0;
        step();
        chk("rst_run_early", 32'(bus.int_run), 32'd0);
        step();
        chk("rst_run_pulse", 32'(bus.int_run), 32'd1);
        step();
        chk("idle_wait", 32'(bus.int_wait), 32'd0);
        chk("idle_run", 32'(bus.int_run), 32'd0);

        // 2: mask 0110, irq 1 and 2 together; 1 first, then 2
        cpu_instr = setmask(4'b0110);
        cpu_valid = 1'b1;
        step();
        cpu_valid = 1'b0;
        bus.irq = 4'b0110;
        step();
        bus.irq = '0;
        chk("t2_pending", 32'(bus.pending), 32'h6);
        chk("t2_accept_wait", 32'(bus.int_wait), 32'd1);
        sb_q.push_back('{32'h1100, 5'd1, 32'h100});
        step();
        chk("t2_vec1", bus.pc_int, 32'hC);
        chk("t2_active1", 32'(bus.active_src), 32'd1);
        chk("t2_pend_left", 32'(bus.pending), 32'h4);
        wait_run(12, "t2_run1", n);
        chk("t2_latency", 32'(n + 1), 32'(3 + FW));
        step();
        chk("t2_isr_wait", 32'(bus.int_wait), 32'd0);
        reti_and_wait("t2_done1", n);
        chk("t2_drain1", 32'(n), 32'(DC));
        bus.pc_curr = 32'h140;
        sb_q.push_back('{32'h1200, 5'd2, 32'h140});
        step();
        chk("t2_accept2", 32'(bus.int_wait), 32'd1);
        step();
        chk("t2_vec2", bus.pc_int, 32'h10);
        wait_run(12, "t2_run2", n);
        step();
        reti_and_wait("t2_done2", n);

        // 3: masked request only pends; enabling the mask starts service
        step();
        cpu_instr = setmask(4'b0000);
        cpu_valid = 1'b1;
        step();
        cpu_valid = 1'b0;
        bus.irq = 4'b0001;
        step();
        bus.irq = '0;
        step();
        step();
        chk("t3_pending", 32'(bus.pending), 32'h1);
        chk("t3_no_service", 32'(bus.int_wait), 32'd0);
        chk("t3_done_cnt", 32'(done_cnt), 32'd2);
        cpu_instr = setmask(4'b0001);
        cpu_valid = 1'b1;
        step();
        cpu_valid = 1'b0;
        chk("t3_accept", 32'(bus.int_wait), 32'd1);

        // 4: branch on accept sets pc_resume; branch inside ISR does not
        bus.take_branch = 1'b1;
        bus.pc_branch = 32'h200;
        sb_q.push_back('{32'h1000, 5'd0, 32'h200});
        step();
        bus.take_branch = 1'b0;
        chk("t4_resume_acc", bus.pc_resume, 32'h200);
        chk("t3_pend_clr", 32'(bus.pending), 32'h0);
        wait_run(12, "t4_run", n);
        step();
        bus.take_branch = 1'b1;
        bus.pc_branch = 32'h300;
        step();
        bus.take_branch = 1'b0;
        chk("t4_resume_isr", bus.pc_resume, 32'h200);
        reti_and_wait("t4_done", n);

        // 5: branch in 2nd drain cycle squashes RETI; later RETI completes
        step();
        bus.irq = 4'b0001;
        step();
        bus.irq = '0;
        sb_q.push_back('{32'h1000, 5'd0, 32'h140});
        wait_run(12, "t5_run", n);
        step();
        cpu_instr = I_RETI;
        cpu_valid = 1'b1;
        step();
        cpu_valid = 1'b0;
        chk("t5_drain_wait", 32'(bus.int_wait), 32'd1);
        step();
        bus.take_branch = 1'b1;
        #1;
        chk("t5_squash_wait", 32'(bus.int_wait), 32'd0);
        chk("t5_squash_done", 32'(bus.int_done), 32'd0);
        step();
        bus.take_branch = 1'b0;
        chk("t5_back_isr", 32'(bus.int_wait), 32'd0);
        step();
        chk("t5_still_isr", 32'(bus.int_wait), 32'd0);
        chk("t5_done_cnt", 32'(done_cnt), 32'd3);
        reti_and_wait("t5_done", n);
        chk("t5_drain_len", 32'(n), 32'(DC));

        // 6: reset in WAIT clears pending/mask and restarts at RST_VEC
        step();
        bus.irq = 4'b0011;
        step();
        bus.irq = '0;
        step();
        chk("t6_pend_before", 32'(bus.pending), 32'h2);
        step();
        step();
        chk("t6_in_wait", bus.pc_int, 32'h8);
        rst = 1'b1;
        step();
        chk("t6_pending", 32'(bus.pending), 32'h0);
        chk("t6_pc_int", bus.pc_int, 32'h0);
        chk("t6_wait", 32'(bus.int_wait), 32'd1);
        chk("t6_active", 32'(bus.active_src), 32'd0);
        chk("t6_resume", bus.pc_resume, 32'h0);
        sb_q.push_back('{H_RST, 5'd0, 32'h0});
        rst = 1'b0;
        step();
        step();
        chk("t6_rst_run", 32'(bus.int_run), 32'd1);
        step();
        bus.irq = 4'b0001;
        step();
        bus.irq = '0;
        step();
        step();
        chk("t6_mask_clr", 32'(bus.int_wait), 32'd0);
        chk("t6_pend_new", 32'(bus.pending), 32'h1);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
